pang_sft_ctrl: RTL and testbench

Sequencing controller for the 16-lane, 5-stage pipelined byte-shift datapath (`muxpang_pipe5`). It tracks how many valid bytes occupy the 16-byte window. It grants consumer take requests and admits 8-byte refills from upstream, and it drives the datapath's `next_sft` every cycle. A delayed valid/length pair is aligned with the datapath's output so downstream logic knows which shifted words carry data.

---
 rtl/pang_sft_ctrl.sv | 115 +++++++++++
 tb/tb_pang_sft_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pang_sft_ctrl.sv
// rtl/pang_sft_ctrl.sv - shift/refill sequencer for the 16-lane byte-shift pipe
// Optional statistics counters are built when PANG_CTRL_STATS_EN is defined.
module pang_sft_ctrl #(
  parameter int PIPE_DEPTH = 5,
  parameter int FILL_BYTES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cons_req,
  input  logic [3:0]  cons_len,
  output logic        cons_gnt,
  input  logic        fill_valid,
  output logic        fill_ready,
  input  logic        flush,
  output logic [3:0]  next_sft,
  output logic [4:0]  fill_pos,
  output logic        fill_load,
  output logic [4:0]  level,
  output logic        pipe_valid,
  output logic [3:0]  pipe_len,
`ifdef PANG_CTRL_STATS_EN
  output logic [31:0] stat_bytes,
  output logic [31:0] stat_stall,
`endif
  output logic        busy
);

  localparam logic [4:0] FILL_B5  = 5'(FILL_BYTES);
  localparam logic [4:0] FILL_MAX = 5'(16 - FILL_BYTES);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t                state;
  logic [PIPE_DEPTH-1:0] vld_sr;
  logic [3:0]            len_sr [PIPE_DEPTH];
  logic [3:0]            flush_amt;
  logic [3:0]            shift_amt;
  logic                  shift_issued;
  logic                  fill_acc;
  logic [4:0]            post;
  logic [4:0]            level_nxt;
  logic                  pipe_empty_nxt;

  always_comb begin
    flush_amt      = (level >= 5'd15) ? 4'd15 : level[3:0];
    cons_gnt       = cons_req && (cons_len != 4'd0) && ({1'b0, cons_len} <= level)
                     && (state == RUN);
    shift_issued   = cons_gnt || ((state == FLUSH) && (flush_amt != 4'd0));
    shift_amt      = cons_gnt ? cons_len : ((state == FLUSH) ? flush_amt : 4'd0);
    post           = level - {1'b0, shift_amt};
    fill_ready     = ((state == IDLE) || (state == RUN)) && (post <= FILL_MAX);
    fill_acc       = fill_valid && fill_ready;
    level_nxt      = post + (fill_acc ? FILL_B5 : 5'd0);
    // Empty after this edge: nothing issued now, nothing waiting to enter or inside the pipe.
    pipe_empty_nxt = !shift_issued && (next_sft == 4'd0)
                     && (vld_sr[PIPE_DEPTH-2:0] == '0);
    busy           = (state != IDLE);
    pipe_valid     = vld_sr[PIPE_DEPTH-1];
    pipe_len       = len_sr[PIPE_DEPTH-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      next_sft  <= 4'd0;
      fill_pos  <= 5'd0;
      fill_load <= 1'b0;
      level     <= 5'd0;
      vld_sr    <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) len_sr[i] <= 4'd0;
    end else begin
      next_sft  <= shift_amt;
      fill_load <= fill_acc;
      if (fill_acc) fill_pos <= post;
      level     <= level_nxt;
      vld_sr    <= {vld_sr[PIPE_DEPTH-2:0], next_sft != 4'd0};
      len_sr[0] <= next_sft;
      for (int i = 1; i < PIPE_DEPTH; i++) len_sr[i] <= len_sr[i-1];
      case (state)
        IDLE:  if (fill_acc) state <= RUN;
        RUN: begin
          if (flush)                                 state <= (level_nxt != 5'd0) ? FLUSH : DRAIN;
          else if (level_nxt == 5'd0 && pipe_empty_nxt) state <= IDLE;
        end
        FLUSH: if (level_nxt == 5'd0) state <= DRAIN;
        DRAIN: if (pipe_empty_nxt)    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PANG_CTRL_STATS_EN
  logic [32:0] bytes_sum;
  logic [32:0] stall_sum;

  always_comb begin
    bytes_sum = {1'b0, stat_bytes} + 33'(cons_len);
    stall_sum = {1'b0, stat_stall} + 33'd1;
  end

  // Only consumer grants count as bytes; flush self-shifts never assert cons_gnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_bytes <= 32'd0;
      stat_stall <= 32'd0;
    end else begin
      if (cons_gnt)
        stat_bytes <= bytes_sum[32] ? 32'hFFFF_FFFF : bytes_sum[31:0];
      if (cons_req && !cons_gnt)
        stat_stall <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_pang_sft_ctrl.sv
// tb/tb_pang_sft_ctrl.sv - directed vector bench for pang_sft_ctrl
module tb_pang_sft_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cons_req;
  logic [3:0]  cons_len;
  logic        cons_gnt;
  logic        fill_valid;
  logic        fill_ready;
  logic        flush;
  logic [3:0]  next_sft;
  logic [4:0]  fill_pos;
  logic        fill_load;
  logic [4:0]  level;
  logic        pipe_valid;
  logic [3:0]  pipe_len;
  logic        busy;
`ifdef PANG_CTRL_STATS_EN
  logic [31:0] stat_bytes;
  logic [31:0] stat_stall;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pang_sft_ctrl dut (
    .clk(clk), .reset(reset),
    .cons_req(cons_req), .cons_len(cons_len), .cons_gnt(cons_gnt),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .flush(flush),
    .next_sft(next_sft), .fill_pos(fill_pos), .fill_load(fill_load),
    .level(level), .pipe_valid(pipe_valid), .pipe_len(pipe_len),
`ifdef PANG_CTRL_STATS_EN
    .stat_bytes(stat_bytes), .stat_stall(stat_stall),
`endif
    .busy(busy)
  );

  typedef struct {
    logic       req;
    logic [3:0] len;
    logic       fv;
    logic       e_gnt;
    logic       e_fr;
    logic [4:0] e_level;
    logic [3:0] e_sft;
    logic       e_load;
    logic [4:0] e_pos;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [3:0] len, input logic fv, input logic fl);
    cons_req   = req;
    cons_len   = len;
    fill_valid = fv;
    flush      = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  int k;
  int npv;
  int lens [2];

  initial begin
    //          req len   fv   gnt  fr   level  sft  load pos
    vecs[0]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 5'd8,  4'd0, 1'b1, 5'd0};
    vecs[1]  = '{1'b1, 4'd3,  1'b0, 1'b1, 1'b1, 5'd5,  4'd3, 1'b0, 5'd0};
    vecs[2]  = '{1'b1, 4'd5,  1'b1, 1'b1, 1'b1, 5'd8,  4'd5, 1'b1, 5'd0};
    vecs[3]  = '{1'b1, 4'd5,  1'b1, 1'b1, 1'b1, 5'd11, 4'd5, 1'b1, 5'd3};
    vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd11, 4'd0, 1'b0, 5'd0};
    vecs[5]  = '{1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 5'd9,  4'd2, 1'b0, 5'd0};
    vecs[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 5'd9,  4'd0, 1'b0, 5'd0};
    vecs[7]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 5'd9,  4'd0, 1'b0, 5'd0};
    vecs[8]  = '{1'b1, 4'd9,  1'b0, 1'b1, 1'b1, 5'd0,  4'd9, 1'b0, 5'd0};
    vecs[9]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 5'd0,  4'd0, 1'b0, 5'd0};
    vecs[10] = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 5'd0,  4'd0, 1'b0, 5'd0};

    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    repeat (2) cyc();
    reset = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_next_sft", next_sft, 0);
    chk("rst_fill_pos", fill_pos, 0);
    chk("rst_fill_load", fill_load, 0);
    chk("rst_pipe_valid", pipe_valid, 0);
    chk("rst_pipe_len", pipe_len, 0);
    chk("rst_busy", busy, 0);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].req, vecs[i].len, vecs[i].fv, 1'b0);
      #2;
      chk($sformatf("v%0d_gnt", i), cons_gnt, vecs[i].e_gnt);
      chk($sformatf("v%0d_fill_ready", i), fill_ready, vecs[i].e_fr);
      cyc();
      chk($sformatf("v%0d_level", i), level, vecs[i].e_level);
      chk($sformatf("v%0d_next_sft", i), next_sft, vecs[i].e_sft);
      chk($sformatf("v%0d_fill_load", i), fill_load, vecs[i].e_load);
      if (vecs[i].e_load) chk($sformatf("v%0d_fill_pos", i), fill_pos, vecs[i].e_pos);
      if (i == 0) chk("v0_busy", busy, 1);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    k = 0;
    while (busy && k < 20) begin cyc(); k++; end
    chk("table_idle_busy", busy, 0);

    // Grant latency to pipe_valid.
    do_reset();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    #2;
    chk("lat_gnt", cons_gnt, 1);
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    chk("lat_next_sft", next_sft, 3);
    k = 1;
    while (!pipe_valid && k < 20) begin cyc(); k++; end
    chk("lat_pipe_valid_cycles", k, 6);
    chk("lat_pipe_len", pipe_len, 3);
    cyc();
    chk("lat_pipe_valid_single", pipe_valid, 0);

    // Oversized request held off until a refill.
    do_reset();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 4'd4, 1'b0, 1'b0);
    cyc();
    chk("stall_level4", level, 4);
    drive(1'b1, 4'd6, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("stall_gnt%0d", i), cons_gnt, 0);
      cyc();
    end
    drive(1'b1, 4'd6, 1'b1, 1'b0);
    #2;
    chk("stall_fill_gnt", cons_gnt, 0);
    chk("stall_fill_ready", fill_ready, 1);
    cyc();
    chk("stall_level12", level, 12);
    drive(1'b1, 4'd6, 1'b0, 1'b0);
    #2;
    chk("stall_gnt_after_fill", cons_gnt, 1);
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    chk("stall_level6", level, 6);
    chk("stall_next_sft", next_sft, 6);
`ifdef PANG_CTRL_STATS_EN
    chk("stat_stall", stat_stall, 4);
    chk("stat_bytes", stat_bytes, 10);
`endif

    // Flush from a full window.
    do_reset();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    cyc();
    cyc();
    chk("flush_level16", level, 16);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 4'd2, 1'b1, 1'b0);
    #2;
    chk("flush1_gnt", cons_gnt, 0);
    chk("flush1_fill_ready", fill_ready, 0);
    cyc();
    chk("flush1_next_sft", next_sft, 15);
    chk("flush1_level", level, 1);
    #2;
    chk("flush2_gnt", cons_gnt, 0);
    chk("flush2_fill_ready", fill_ready, 0);
    cyc();
    chk("flush2_next_sft", next_sft, 1);
    chk("flush2_level", level, 0);
    npv = 0;
    k = 0;
    while (busy && k < 20) begin
      #2;
      if (cons_gnt || fill_ready) chk("drain_no_accept", 1, 0);
      cyc();
      if (pipe_valid) begin
        if (npv < 2) lens[npv] = int'(pipe_len);
        npv++;
      end
      k++;
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    chk("drain_busy", busy, 0);
    chk("drain_pipe_valid_count", npv, 2);
    chk("drain_len0", lens[0], 15);
    chk("drain_len1", lens[1], 1);
    chk("drain_pipe_valid_low", pipe_valid, 0);
    chk("drain_level", level, 0);

    // Asynchronous reset two cycles after a grant.
    do_reset();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_next_sft", next_sft, 0);
    chk("arst_busy", busy, 0);
    cyc();
    reset = 1'b0;
    npv = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (pipe_valid) npv++;
    end
    chk("arst_no_pipe_valid", npv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
